// File: rtl/bulls_cows_param.sv
// Two-player Bulls & Cows game controller.
// Each player enters a secret. Players then take turns guessing the opponent's
// secret. Each guess is scored as bulls (right digit, right place) and cows
// (right digit, wrong place).
//
// Optional feature: define BC_DUP_REJECT_EN to reject entries containing repeated digits.
//
// Ports:
//   clock, reset     - rising-edge clock, synchronous active-high reset
//   SW               - digit entry, digit k at SW[k*DW +: DW]
//   ssl              - enter key (level); one action per rising edge
//   disp             - eight 6-bit display codes, d1 at [5:0] .. d8 at [47:42]
//   bulls, cows      - result of the last accepted guess
//   turn             - 0: player 1 guessing, 1: player 2 guessing
//   tries1, tries2   - guesses consumed per player
//   p1_win, p2_win   - one-cycle pulse on entry to WIN
//   draw             - high while in DRAW
module bulls_cows_param #(
    parameter int unsigned NDIG      = 4,
    parameter int unsigned DW        = 4,
    parameter int unsigned MAX_TRIES = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NDIG*DW-1:0] SW,
    input  logic               ssl,
    output logic [47:0]        disp,
    output logic [3:0]         bulls,
    output logic [3:0]         cows,
    output logic               turn,
    output logic [3:0]         tries1,
    output logic [3:0]         tries2,
    output logic               p1_win,
    output logic               p2_win,
    output logic               draw
);

    localparam int unsigned SW_W  = NDIG * DW;
    localparam logic [5:0]  BLANK = 6'b100000;
    localparam logic [3:0]  MT4   = 4'(MAX_TRIES);

    typedef enum logic [2:0] {
        S_SET1, S_SET2, S_GUESS, S_RESULT, S_WIN, S_DRAW, S_ERR
    } state_t;

    state_t          state_q, state_d, ret_q, ret_d;
    logic            turn_q, turn_d, ssl_q;
    logic [SW_W-1:0] secret1_q, secret1_d, secret2_q, secret2_d;
    logic [3:0]      tries1_q, tries1_d, tries2_q, tries2_d;
    logic [3:0]      bulls_q, bulls_d, cows_q, cows_d;
    logic            p1_win_q, p1_win_d, p2_win_q, p2_win_d, draw_q, draw_d;
    logic [47:0]     disp_q, disp_d;

    logic            rise_c, valid_c;
    logic [SW_W-1:0] opp_c;
    logic [7:0]      bull_cnt_c, cow_cnt_c;
    logic [3:0]      bulls_sat_c, cows_sat_c, tries_cur_c;

    function automatic logic [5:0] glyph(input logic [3:0] g);
        return {1'b0, g, 1'b0};
    endfunction

    // Entry validation: digit range, plus optional duplicate rejection
    always_comb begin
        valid_c = 1'b1;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (32'(SW[i*DW +: DW]) > 32'd9) valid_c = 1'b0;
        end
`ifdef BC_DUP_REJECT_EN
        for (int i = 0; i < int'(NDIG); i++) begin
            for (int j = i + 1; j < int'(NDIG); j++) begin
                if (SW[i*DW +: DW] == SW[j*DW +: DW]) valid_c = 1'b0;
            end
        end
`endif
    end

    // Score the entry against the opponent's secret; cows count ordered pairs
    always_comb begin
        opp_c      = turn_q ? secret1_q : secret2_q;
        bull_cnt_c = 8'd0;
        cow_cnt_c  = 8'd0;
        for (int i = 0; i < int'(NDIG); i++) begin
            for (int j = 0; j < int'(NDIG); j++) begin
                if (opp_c[i*DW +: DW] == SW[j*DW +: DW]) begin
                    if (i == j) bull_cnt_c = bull_cnt_c + 8'd1;
                    else        cow_cnt_c  = cow_cnt_c + 8'd1;
                end
            end
        end
        bulls_sat_c = (bull_cnt_c > 8'd15) ? 4'd15 : 4'(bull_cnt_c);
        cows_sat_c  = (cow_cnt_c > 8'd15)  ? 4'd15 : 4'(cow_cnt_c);
    end

    // Next-state and register updates, one action per enter edge
    always_comb begin
        rise_c    = ssl & ~ssl_q;
        state_d   = state_q;
        ret_d     = ret_q;
        turn_d    = turn_q;
        secret1_d = secret1_q;
        secret2_d = secret2_q;
        tries1_d  = tries1_q;
        tries2_d  = tries2_q;
        bulls_d   = bulls_q;
        cows_d    = cows_q;
        p1_win_d  = 1'b0;
        p2_win_d  = 1'b0;
        if (rise_c) begin
            case (state_q)
                S_SET1, S_SET2: begin
                    if (!valid_c) begin
                        ret_d   = state_q;
                        state_d = S_ERR;
                    end else if (state_q == S_SET1) begin
                        secret1_d = SW;
                        state_d   = S_SET2;
                    end else begin
                        secret2_d = SW;
                        turn_d    = 1'b0;
                        state_d   = S_GUESS;
                    end
                end
                S_GUESS: begin
                    if (!valid_c) begin
                        ret_d   = S_GUESS;
                        state_d = S_ERR;
                    end else begin
                        if (turn_q) tries2_d = 4'(tries2_q + 4'd1);
                        else        tries1_d = 4'(tries1_q + 4'd1);
                        bulls_d = bulls_sat_c;
                        cows_d  = cows_sat_c;
                        if (bull_cnt_c == 8'(NDIG)) begin
                            state_d  = S_WIN;
                            p1_win_d = ~turn_q;
                            p2_win_d = turn_q;
                        end else begin
                            state_d = S_RESULT;
                        end
                    end
                end
                S_RESULT: begin
                    if (tries1_q == MT4 && tries2_q == MT4) begin
                        state_d = S_DRAW;
                    end else begin
                        turn_d  = ~turn_q;
                        state_d = S_GUESS;
                    end
                end
                S_WIN, S_DRAW: begin
                    state_d   = S_SET1;
                    secret1_d = '0;
                    secret2_d = '0;
                    tries1_d  = 4'd0;
                    tries2_d  = 4'd0;
                    bulls_d   = 4'd0;
                    cows_d    = 4'd0;
                end
                S_ERR:   state_d = ret_q;
                default: state_d = S_SET1;
            endcase
        end
        draw_d = (state_d == S_DRAW);
    end

    // Display image derived from the current state; lands one cycle later
    always_comb begin
        tries_cur_c = turn_q ? tries2_q : tries1_q;
        disp_d      = {8{BLANK}};
        case (state_q)
            S_SET1:   disp_d[23:0] = {glyph(4'hA), glyph(4'd1), glyph(4'hD), glyph(4'hF)};
            S_SET2:   disp_d[23:0] = {glyph(4'hA), glyph(4'd2), glyph(4'hD), glyph(4'hF)};
            S_GUESS:  disp_d[23:0] = {glyph(tries_cur_c), glyph(4'hA),
                                      glyph(4'({3'b000, turn_q} + 4'd1)), glyph(4'd6)};
            S_RESULT: disp_d[23:0] = {glyph(4'hC), glyph(cows_q), glyph(4'hB), glyph(bulls_q)};
            S_WIN:    disp_d[17:0] = {glyph(4'hA), glyph(4'({3'b000, turn_q} + 4'd1)),
                                      glyph(4'hE)};
            S_DRAW:   disp_d[11:0] = {glyph(4'd0), glyph(4'd0)};
            S_ERR:    disp_d[17:0] = {glyph(4'hE), glyph(4'hE), glyph(4'hE)};
            default:  disp_d = {8{BLANK}};
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_SET1;
            ret_q     <= S_SET1;
            turn_q    <= 1'b0;
            ssl_q     <= 1'b0;
            secret1_q <= '0;
            secret2_q <= '0;
            tries1_q  <= 4'd0;
            tries2_q  <= 4'd0;
            bulls_q   <= 4'd0;
            cows_q    <= 4'd0;
            p1_win_q  <= 1'b0;
            p2_win_q  <= 1'b0;
            draw_q    <= 1'b0;
            disp_q    <= {8{BLANK}};
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            turn_q    <= turn_d;
            ssl_q     <= ssl;
            secret1_q <= secret1_d;
            secret2_q <= secret2_d;
            tries1_q  <= tries1_d;
            tries2_q  <= tries2_d;
            bulls_q   <= bulls_d;
            cows_q    <= cows_d;
            p1_win_q  <= p1_win_d;
            p2_win_q  <= p2_win_d;
            draw_q    <= draw_d;
            disp_q    <= disp_d;
        end
    end

    assign disp   = disp_q;
    assign bulls  = bulls_q;
    assign cows   = cows_q;
    assign turn   = turn_q;
    assign tries1 = tries1_q;
    assign tries2 = tries2_q;
    assign p1_win = p1_win_q;
    assign p2_win = p2_win_q;
    assign draw   = draw_q;

endmodule

// File: tb/tb_bulls_cows_param.sv
// Testbench for bulls_cows_param (NDIG=4, DW=4, MAX_TRIES=2).
// A table of key presses is scored through a queue. Hand-written sequences
// then cover the win pulses, a held key, invalid and duplicate entries, and a
// reset that coincides with a key press.
module tb_bulls_cows_param;

    localparam int unsigned NDIG = 4;
    localparam int unsigned DW   = 4;
    localparam int unsigned MT   = 2;

    logic        clock = 1'b0;
    logic        reset, ssl;
    logic [15:0] SW;
    logic [47:0] disp;
    logic [3:0]  bulls, cows, tries1, tries2;
    logic        turn, p1_win, p2_win, draw;

    always #5 clock = ~clock;

    bulls_cows_param #(.NDIG(NDIG), .DW(DW), .MAX_TRIES(MT)) dut (
        .clock(clock), .reset(reset), .SW(SW), .ssl(ssl), .disp(disp),
        .bulls(bulls), .cows(cows), .turn(turn), .tries1(tries1), .tries2(tries2),
        .p1_win(p1_win), .p2_win(p2_win), .draw(draw)
    );

    typedef struct {
        logic [15:0] sw;
        logic [3:0]  b, c;
        logic        t;
        logic [3:0]  t1, t2;
        logic        dr;
        logic [47:0] d;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    vec_t sb[$];

    // Expected display image from a short string; '_' or missing chars are blank
    function automatic logic [47:0] dsp(input string s);
        logic [47:0] r;
        logic [3:0]  g;
        r = {8{6'b100000}};
        for (int i = 0; i < s.len() && i < 8; i++) begin
            case (s[i])
                "P": g = 4'hA;
                "b": g = 4'hB;
                "c": g = 4'hC;
                "S": g = 4'hD;
                "E": g = 4'hE;
                "U": g = 4'hF;
                default: g = 4'(s[i] - 8'h30);
            endcase
            if (s[i] != "_") r[i*6 +: 6] = {1'b0, g, 1'b0};
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic [15:0] sw, input int b, input int c, input int t,
                                input int t1, input int t2, input int dr, input string d);
        vec_t v;
        v.sw = sw; v.b = 4'(b); v.c = 4'(c); v.t = 1'(t);
        v.t1 = 4'(t1); v.t2 = 4'(t2); v.dr = 1'(dr); v.d = dsp(d);
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clean key press; returns once the display reflects the new state
    task automatic press(input logic [15:0] sw);
        @(posedge clock); #1;
        SW = sw; ssl = 1'b1;
        @(posedge clock); #1;
        ssl = 1'b0;
        @(posedge clock); #1;
    endtask

    // Winning press; counts win pulses over the following cycles
    task automatic win_press(input logic [15:0] sw, output int n1, output int n2);
        n1 = 0; n2 = 0;
        @(posedge clock); #1;
        SW = sw; ssl = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clock); #1;
            ssl = 1'b0;
            n1 += int'(p1_win);
            n2 += int'(p2_win);
        end
    endtask

    vec_t v[17];
    vec_t e;
    int   n1, n2;

    initial begin
        v[0]  = mk(16'h1234, 0, 0, 0, 0, 0, 0, "US2P");
        v[1]  = mk(16'h5678, 0, 0, 0, 0, 0, 0, "61P0");
        v[2]  = mk(16'h5687, 2, 2, 0, 1, 0, 0, "2b2c");
        v[3]  = mk(16'h0000, 2, 2, 1, 1, 0, 0, "62P0");
        v[4]  = mk(16'hAB12, 2, 2, 1, 1, 0, 0, "EEE");
        v[5]  = mk(16'h0000, 2, 2, 1, 1, 0, 0, "62P0");
        v[6]  = mk(16'h4321, 0, 4, 1, 1, 1, 0, "0b4c");
        v[7]  = mk(16'h0000, 0, 4, 0, 1, 1, 0, "61P1");
        v[8]  = mk(16'h9012, 0, 0, 0, 2, 1, 0, "0b0c");
        v[9]  = mk(16'h0000, 0, 0, 1, 2, 1, 0, "62P1");
        v[10] = mk(16'h1243, 2, 2, 1, 2, 2, 0, "2b2c");
        v[11] = mk(16'h0000, 2, 2, 1, 2, 2, 1, "00");
        v[12] = mk(16'h0000, 0, 0, 1, 0, 0, 0, "US1P");
        v[13] = mk(16'h1234, 0, 0, 1, 0, 0, 0, "US2P");
        v[14] = mk(16'h5678, 0, 0, 0, 0, 0, 0, "61P0");
        v[15] = mk(16'h5678, 4, 0, 0, 1, 0, 0, "E1P");
        v[16] = mk(16'h0000, 0, 0, 0, 0, 0, 0, "US1P");

        reset = 1'b1; ssl = 1'b0; SW = 16'h0000;
        @(posedge clock); @(posedge clock); #1;
        chk("rst disp", 64'(disp), 64'(dsp("")));
        chk("rst bulls/cows", 64'({bulls, cows}), 64'd0);
        chk("rst tries", 64'({tries1, tries2}), 64'd0);
        chk("rst flags", 64'({turn, p1_win, p2_win, draw}), 64'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("set1 disp", 64'(disp), 64'(dsp("US1P")));

        // Table: full draw game, then a player-1 win
        for (int i = 0; i < 17; i++) begin
            sb.push_back(v[i]);
            press(v[i].sw);
            e = sb.pop_front();
            chk($sformatf("row%0d bulls", i), 64'(bulls), 64'(e.b));
            chk($sformatf("row%0d cows", i), 64'(cows), 64'(e.c));
            chk($sformatf("row%0d turn", i), 64'(turn), 64'(e.t));
            chk($sformatf("row%0d tries", i), 64'({tries1, tries2}), 64'({e.t1, e.t2}));
            chk($sformatf("row%0d draw", i), 64'(draw), 64'(e.dr));
            chk($sformatf("row%0d disp", i), 64'(disp), 64'(e.d));
        end

        // Player 2 wins: one p2_win pulse, no p1_win
        press(16'h1234);
        press(16'h5678);
        press(16'h9012);
        press(16'h0000);
        chk("p2 guess disp", 64'(disp), 64'(dsp("62P0")));
        win_press(16'h1234, n1, n2);
        chk("p2 pulse count", 64'(n2), 64'd1);
        chk("p1 pulse none", 64'(n1), 64'd0);
        chk("p2 win disp", 64'(disp), 64'(dsp("E2P")));
        chk("p2 win score", 64'({bulls, tries2}), 64'({4'd4, 4'd1}));
        press(16'h0000);
        chk("after win disp", 64'(disp), 64'(dsp("US1P")));
        chk("after win tries", 64'({tries1, tries2, bulls}), 64'd0);

        // Out-of-range digit in SET1 goes to ERR and back
        press(16'hA000);
        chk("set1 err disp", 64'(disp), 64'(dsp("EEE")));
        press(16'h0000);
        chk("set1 err ret", 64'(disp), 64'(dsp("US1P")));

        // Duplicate digits in a secret
        press(16'h1123);
`ifdef BC_DUP_REJECT_EN
        chk("dup err", 64'(disp), 64'(dsp("EEE")));
        press(16'h0000);
        chk("dup ret", 64'(disp), 64'(dsp("US1P")));
        press(16'h1234);
`endif
        chk("dup set2", 64'(disp), 64'(dsp("US2P")));

        // Held key: exactly one action
        n1 = 0;
        @(posedge clock); #1;
        SW = 16'h5678; ssl = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clock); #1;
            n1 += int'(p1_win);
        end
        ssl = 1'b0;
        chk("hold disp", 64'(disp), 64'(dsp("61P0")));
        chk("hold no win", 64'(n1), 64'd0);
        chk("hold tries", 64'(tries1), 64'd0);

        // Reset together with a rising enter edge mid-game
        press(16'h9012);
        press(16'h0000);
        chk("pre-reset turn", 64'({turn, tries1}), 64'({1'b1, 4'd1}));
        @(posedge clock); #1;
        SW = 16'h1234; ssl = 1'b1; reset = 1'b1;
        @(posedge clock); #1;
        chk("rr disp", 64'(disp), 64'(dsp("")));
        chk("rr score", 64'({bulls, cows, tries1, tries2}), 64'd0);
        chk("rr flags", 64'({turn, p1_win, p2_win, draw}), 64'd0);
        ssl = 1'b0; reset = 1'b0;
        @(posedge clock); #1;
        chk("rr set1", 64'(disp), 64'(dsp("US1P")));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
